// File: rtl/pio_in_pkg.sv
// Shared definitions for the edge-capturing input PIO: register word
// addresses and the debounce counter sizing helpers.
package pio_in_pkg;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_RAW  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_RISE = 3'd4;
  localparam logic [2:0] ADDR_FALL = 3'd5;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // A single-cycle debounce still needs a one-bit counter vector to exist.
  function automatic int cnt_width(input int cycles);
    return (clog2(cycles) < 1) ? 1 : clog2(cycles);
  endfunction

endpackage

// File: rtl/pio_in_debounce_ch.sv
// One input channel: metastability synchroniser, optional debounce counter
// (enabled by the PIO_IN_DEBOUNCE_EN macro) and the accepted stable level.
module pio_in_debounce_ch
  import pio_in_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_bit,
  output logic synced,
  output logic stable,
  output logic update
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
  assign synced = sync_q[SYNC_STAGES-1];
  assign stable = stable_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    update   = 1'b0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = synced;
        update   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    stable_d = synced;
    update   = (synced != stable_q);
  end
`endif

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO with per-channel edge selection, W1C edge capture and a
// masked level interrupt. Define PIO_IN_DEBOUNCE_EN to add per-channel debounce.
module pio_in_edge_irq
  import pio_in_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RISE_RESET      = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] synced, stable, update;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pio_in_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst_n (reset_n),
      .in_bit(in_port[i]),
      .synced(synced[i]),
      .stable(stable[i]),
      .update(update[i])
    );
  end

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] edge_set, edge_clr;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // At an update the synchroniser output already holds the newly accepted level.
  assign edge_set = (update & synced & rise_q) | (update & ~synced & fall_q);
  assign edge_clr = (wr_en && address == ADDR_EDGE) ? wdata : '0;

  always_comb begin
    mask_d = mask_q;
    rise_d = rise_q;
    fall_d = fall_q;
    edge_d = (edge_q & ~edge_clr) | edge_set;
    if (wr_en) begin
      case (address)
        ADDR_MASK: mask_d = wdata;
        ADDR_RISE: rise_d = wdata;
        ADDR_FALL: fall_d = wdata;
        default:   ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA: rdata_d[WIDTH-1:0] = stable;
      ADDR_RAW:  rdata_d[WIDTH-1:0] = synced;
      ADDR_MASK: rdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rdata_d[WIDTH-1:0] = edge_q;
      ADDR_RISE: rdata_d[WIDTH-1:0] = rise_q;
      ADDR_FALL: rdata_d[WIDTH-1:0] = fall_q;
      default:   ;
    endcase
  end

  // Rise enable comes out of reset set, so an unconfigured part still reports
  // button presses like the fixed-function predecessor.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '0;
      edge_q  <= '0;
      rise_q  <= RISE_RESET;
      fall_q  <= '0;
      rdata_q <= '0;
    end else begin
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
Parametrised Avalon-MM input PIO, successor to the 4-bit button PIO. Adds:
- configurable channel width and synchroniser depth
- per-channel rising and falling edge selection
- bitwise write-1-to-clear edge capture
- interrupt mask and level irq output
- optional per-channel debounce

Sits on the system interconnect between board buttons/switches and the Nios/Patmos software monitor.

Parameters:
WIDTH, 4, number of input channels (1..32)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a new level (>=1; used only with the macro)
RISE_RESET, all-ones, reset value of rise-enable register (legacy rising-edge behaviour)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  register word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits [WIDTH-1:0] used
readdata  out  32  registered read data; upper bits zero
in_port  in  WIDTH  asynchronous external inputs
irq  out  1  level interrupt

Behaviour:
- Clock and reset: one clock (clk). Reset (reset_n) is asynchronous and active-low. All flops clear on reset_n low except rise_en, which loads RISE_RESET.
- Reset values:
  - readdata 0, irq 0, edge_capture 0, irq_mask 0, fall_en 0
  - synchronisers 0, stable 0, debounce counters 0
- Synchroniser: in_port passes through a SYNC_STAGES flop chain per channel to give synced.
- Debounce (macro defined), per channel:
  - counter width is clog2(DEBOUNCE_CYCLES)
  - when synced != stable: counter increments
  - when counter == DEBOUNCE_CYCLES-1 and the mismatch still holds: stable <= synced, counter <= 0, update pulse asserted this cycle
  - any cycle with synced == stable: counter <= 0
  - a glitch shorter than DEBOUNCE_CYCLES never changes stable
- Edge detect, per channel:
  - rise = update & new value 1 & rise_en
  - fall = update & new value 0 & fall_en
  - edge_capture[i] sets on the same clock edge that stable changes
- Capture clear: a write to address 3 clears the bits where writedata is 1 (W1C).
  - Simultaneous clear and new edge on the same bit: the edge wins (bit stays 1).
- irq = |(edge_capture & irq_mask), driven from registered state. No extra latency beyond capture.
- Register map (read, write):
  - 0: stable (RO)
  - 1: synced raw (RO)
  - 2: irq_mask (RW)
  - 3: edge_capture (R, W1C)
  - 4: rise_en (RW)
  - 5: fall_en (RW)
  - 6..7: read 0, writes ignored
- Writes take effect when chipselect && !write_n.
- readdata is registered every cycle from address (chipselect ignored for reads): 1-cycle read latency.
- Changing rise_en/fall_en does not alter bits already captured.
- Reset mid-debounce discards any pending count.

Optional Feature:
PIO_IN_DEBOUNCE_EN
- Defined: debounce counters are present as described above.
- Undefined: no counters; stable <= synced every cycle and update = (synced != stable). Edge latency is then SYNC_STAGES+1 clocks and DEBOUNCE_CYCLES is ignored.

Decomposition:
- Package pio_in_pkg:
  - register address constants (ADDR_DATA=0, ADDR_RAW=1, ADDR_MASK=2, ADDR_EDGE=3, ADDR_RISE=4, ADDR_FALL=5)
  - clog2 function for the counter width
- Sub-module pio_in_debounce_ch, generated WIDTH times:
  - contains the synchroniser, debounce counter and stable register
  - outputs synced, stable and update

Test Plan:
1. WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, macro on. in_port[0] goes 0->1 and holds; mask=0x1. -> stable[0] and edge_capture[0] become 1 together, 6 clocks after the change; irq=1 on the same cycle; read addr 0 returns 0x1 and addr 3 returns 0x1.
2. Same configuration. in_port[1] pulses high for 3 cycles. -> stable, edge_capture and irq stay 0.
3. fall_en=0x4, rise_en=0. in_port[2] goes 1->0 after settling high. -> edge_capture=0x4. Then write 0x4 to addr 3 -> edge_capture=0x0 and irq=0.
4. edge_capture=0x3; write 0x1 to addr 3 on the same clock that a new rise on ch0 updates. -> edge_capture stays 0x3. Write 0x2 -> 0x1.
5. reset_n asserted 2 cycles into a ch3 debounce, then released with in_port[3] still high. -> all registers read 0 except rise_en=0xF; stable[3] rises DEBOUNCE_CYCLES+2 clocks after release.
6. Macro off. in_port[0] rises. -> edge_capture[0]=1 three clocks later. Read addr 7 -> 0.
